atm_controller_mc: RTL and testbench
====================================

Name: atm_controller_mc

Overview:
- Parametrised, session-based ATM transaction engine; successor to the single-account ATM block.
- Serves NUM_ACCOUNTS accounts with per-account PIN, balance and lockout, through a valid/ready request port and a one-cycle response pulse.
- Replaces the single error bit with encoded status codes.
- Adds deposit, PIN change, a failed-PIN lockout and an idle-session timeout.

Parameters:
- NUM_ACCOUNTS, 8, number of accounts held on chip.
- ACC_W, 12, account-number width.
- ACC_BASE, 2176, account number of index 0; valid numbers are ACC_BASE..ACC_BASE+NUM_ACCOUNTS-1.
- PIN_W, 4, PIN width.
- DEFAULT_PIN, 4'b0100, reset PIN of index i is DEFAULT_PIN ^ i[PIN_W-1:0].
- BAL_W, 11, balance and amount width (unsigned).
- INIT_BALANCE, 500, reset balance of every account.
- MAX_TRIES, 3, consecutive wrong PINs that lock an account.
- TIMEOUT_CYCLES, 64, idle cycles in a session before auto-logout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  3  0 LOGIN, 1 BALANCE, 2 WITHDRAW, 3 DEPOSIT, 4 TRANSFER, 5 LOGOUT, 6 CHANGE_PIN, 7 reserved.
- req_acc  in  ACC_W  account number (LOGIN) or destination account number (TRANSFER).
- req_pin  in  PIN_W  PIN (LOGIN) or new PIN (CHANGE_PIN).
- req_amount  in  BAL_W  amount.
- resp_valid  out  1  one-cycle response pulse.
- resp_status  out  4  0 OK, 1 BAD_ACC, 2 BAD_PIN, 3 LOCKED, 4 NO_SESSION, 5 INSUFFICIENT, 6 OVERFLOW, 7 TIMEOUT, 8 BAD_OP.
- resp_balance  out  BAL_W  session balance after the operation; 0 when no session.
- session_active  out  1  a user is logged in.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - FSM to IDLE; all outputs 0; req_ready goes high on the first clock after release.
  - Balances reset to INIT_BALANCE, PINs to their defaults; try counters and locks cleared.
- FSM states: IDLE (no session), SESSION, EXEC, EXEC2, RESP.
  - IDLE/SESSION: req_ready=1. An accepted request in cycle N moves to EXEC; req_ready=0 until RESP completes.
  - EXEC: decode and check; perform the single write; go to RESP, or to EXEC2 for a TRANSFER credit.
  - RESP: resp_valid=1 for exactly one cycle; return to SESSION or IDLE.
- Latency: resp_valid is asserted in cycle N+2 (TRANSFER: N+3). Exactly one response per accepted request; no overlap.
- LOGIN:
  - If in a session, that session is ended first.
  - Account out of range -> BAD_ACC.
  - Account locked -> LOCKED; the try counter is not changed.
  - Wrong PIN -> increment the try counter. If the counter reaches MAX_TRIES, set the lock and report LOCKED; otherwise report BAD_PIN.
  - Correct PIN -> clear the counter, open the session, report OK with the current balance.
- Any other op with no session -> NO_SESSION, no state change. Reserved op -> BAD_OP, no state change.
- WITHDRAW: amount > balance -> INSUFFICIENT, balance unchanged; else subtract. Amount 0 -> OK.
- DEPOSIT: balance+amount computed at BAL_W+1 bits; > 2^BAL_W-1 -> OVERFLOW, unchanged.
- TRANSFER:
  - Destination out of range, or equal to the session account -> BAD_ACC.
  - amount > balance -> INSUFFICIENT.
  - Destination credit would overflow -> OVERFLOW.
  - All checks are made in EXEC before any write; on any error, neither account is modified.
  - On success: debit in EXEC, credit in EXEC2.
- LOGOUT: report OK with balance 0, close the session.
- CHANGE_PIN: store req_pin for the session account; report OK.
- Timeout:
  - The idle counter runs only in SESSION and clears on every accepted request.
  - On reaching TIMEOUT_CYCLES: req_ready=0 that cycle (timeout wins over a simultaneous req_valid); go to RESP with TIMEOUT, balance 0; session closed.
- Locks persist until reset. session_active is registered and updates with the RESP cycle.

Decomposition:
- Package atm_pkg: op and status enums, FSM state enum, the request struct.
- Sub-module atm_account_store: balance/PIN/try/lock arrays, one read-address port, one write port, asynchronous reset to parameter defaults.

Test Plan:
- Login 2178 PIN 0110 -> OK, balance 500 at N+2. WITHDRAW 100 -> OK 400. BALANCE -> 400.
- From the 400 state, WITHDRAW 450 -> INSUFFICIENT, balance stays 400. Op 7 -> BAD_OP.
- TRANSFER 50 to 2180 -> OK 350 at N+3. LOGOUT. Login 2180 PIN 0000 -> OK 550. DEPOSIT 1500 -> OVERFLOW, balance 550.
- Login 2181 with PIN 1111 three times -> BAD_PIN, BAD_PIN, LOCKED. Then correct PIN 0001 -> LOCKED.
- Login 2183, then hold req_valid=0 for 64 cycles -> resp TIMEOUT, session_active=0. Then BALANCE -> NO_SESSION.
- Assert rst_n=0 in the EXEC2 cycle of a TRANSFER -> outputs 0 immediately; after release, login shows balance 500 for both accounts.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared types for the multi-account ATM controller.
//   op_e     - request opcodes carried on req_op
//   status_e - response codes carried on resp_status
//   state_e  - controller FSM states
//   req_t    - captured request; field widths are the default port widths,
//              so ACC_W/PIN_W/BAL_W overrides must not exceed them
package atm_pkg;

    localparam int ATM_ACC_W = 12;
    localparam int ATM_PIN_W = 4;
    localparam int ATM_BAL_W = 11;

    typedef enum logic [2:0] {
        OP_LOGIN      = 3'd0,
        OP_BALANCE    = 3'd1,
        OP_WITHDRAW   = 3'd2,
        OP_DEPOSIT    = 3'd3,
        OP_TRANSFER   = 3'd4,
        OP_LOGOUT     = 3'd5,
        OP_CHANGE_PIN = 3'd6,
        OP_RSVD       = 3'd7
    } op_e;

    typedef enum logic [3:0] {
        ST_OK           = 4'd0,
        ST_BAD_ACC      = 4'd1,
        ST_BAD_PIN      = 4'd2,
        ST_LOCKED       = 4'd3,
        ST_NO_SESSION   = 4'd4,
        ST_INSUFFICIENT = 4'd5,
        ST_OVERFLOW     = 4'd6,
        ST_TIMEOUT      = 4'd7,
        ST_BAD_OP       = 4'd8
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SESSION,
        S_EXEC,
        S_EXEC2,
        S_RESP
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [ATM_ACC_W-1:0] acc;
        logic [ATM_PIN_W-1:0] pin;
        logic [ATM_BAL_W-1:0] amount;
    } req_t;

endpackage

// File: rtl/atm_controller_mc_if.sv
// atm_controller_mc_if: request/response bus of the ATM controller.
//   req_valid/req_ready handshake with req_op, req_acc, req_pin, req_amount;
//   resp_valid one-cycle pulse with resp_status, resp_balance;
//   session_active level.
//   master: request issuer (host); slave: the controller.
interface atm_controller_mc_if #(
    parameter int ACC_W = 12,
    parameter int PIN_W = 4,
    parameter int BAL_W = 11
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [ACC_W-1:0] req_acc;
    logic [PIN_W-1:0] req_pin;
    logic [BAL_W-1:0] req_amount;
    logic             resp_valid;
    logic [3:0]       resp_status;
    logic [BAL_W-1:0] resp_balance;
    logic             session_active;

    modport master (
        output req_valid, req_op, req_acc, req_pin, req_amount,
        input  req_ready, resp_valid, resp_status, resp_balance, session_active
    );

    modport slave (
        input  req_valid, req_op, req_acc, req_pin, req_amount,
        output req_ready, resp_valid, resp_status, resp_balance, session_active
    );
endinterface

// File: rtl/atm_account_store.sv
// atm_account_store: per-account balance, PIN, failed-try counter and lock.
//   rd_idx -> rd_bal/rd_pin/rd_tries/rd_lock : combinational read port
//   wr_idx + per-field enables                : single write port
//   rst_n (async, active-low) restores balances to INIT_BALANCE,
//   PINs to DEFAULT_PIN ^ index, clears tries and locks.
module atm_account_store #(
    parameter int               NUM_ACCOUNTS = 8,
    parameter int               IDX_W        = 3,
    parameter int               PIN_W        = 4,
    parameter int               BAL_W        = 11,
    parameter int               TRY_W        = 2,
    parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'b0100,
    parameter int               INIT_BALANCE = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [BAL_W-1:0] rd_bal,
    output logic [PIN_W-1:0] rd_pin,
    output logic [TRY_W-1:0] rd_tries,
    output logic             rd_lock,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_bal_en,
    input  logic [BAL_W-1:0] wr_bal,
    input  logic             wr_pin_en,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic             wr_try_en,
    input  logic [TRY_W-1:0] wr_try,
    input  logic             wr_lock_set
);
    logic [BAL_W-1:0] bal   [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin   [NUM_ACCOUNTS];
    logic [TRY_W-1:0] tries [NUM_ACCOUNTS];
    logic             lock  [NUM_ACCOUNTS];

    assign rd_bal   = bal[rd_idx];
    assign rd_pin   = pin[rd_idx];
    assign rd_tries = tries[rd_idx];
    assign rd_lock  = lock[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ACCOUNTS; i++) begin
                bal[i]   <= BAL_W'(INIT_BALANCE);
                pin[i]   <= DEFAULT_PIN ^ PIN_W'(i);
                tries[i] <= '0;
                lock[i]  <= 1'b0;
            end
        end else begin
            if (wr_bal_en)   bal[wr_idx]   <= wr_bal;
            if (wr_pin_en)   pin[wr_idx]   <= wr_pin;
            if (wr_try_en)   tries[wr_idx] <= wr_try;
            if (wr_lock_set) lock[wr_idx]  <= 1'b1;
        end
    end
endmodule

// File: rtl/atm_controller_mc.sv
// atm_controller_mc: session-based multi-account ATM transaction engine.
//   clk, rst_n (async active-low)
//   bus (slave): valid/ready request in, one-cycle response pulse out,
//                registered session_active.
// Response arrives two cycles after acceptance (three for TRANSFER, whose
// credit is written in a second execute cycle).
module atm_controller_mc
    import atm_pkg::*;
#(
    parameter int               NUM_ACCOUNTS   = 8,
    parameter int               ACC_W          = 12,
    parameter int               ACC_BASE       = 2176,
    parameter int               PIN_W          = 4,
    parameter logic [PIN_W-1:0] DEFAULT_PIN    = 4'b0100,
    parameter int               BAL_W          = 11,
    parameter int               INIT_BALANCE   = 500,
    parameter int               MAX_TRIES      = 3,
    parameter int               TIMEOUT_CYCLES = 64
) (
    input logic                clk,
    input logic                rst_n,
    atm_controller_mc_if.slave bus
);
    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ACC_W-1:0] BASE = ACC_W'(ACC_BASE);
    localparam logic [ACC_W:0]   NUM  = (ACC_W + 1)'(NUM_ACCOUNTS);

    state_e           state, state_n;
    status_e          status_q, status_n;
    req_t             req_q;
    logic             started;
    logic             sess_open, sess_open_n;
    logic [IDX_W-1:0] sess_idx, sess_idx_n, dest_idx, dest_idx_n;
    logic [BAL_W-1:0] sess_bal, sess_bal_n, bal_q, bal_n, credit_q, credit_n;
    logic [CNT_W-1:0] idle_cnt;

    logic [BAL_W-1:0] rd_bal, wr_bal;
    logic [PIN_W-1:0] rd_pin, wr_pin;
    logic [TRY_W-1:0] rd_tries, wr_try;
    logic             rd_lock, wr_bal_en, wr_pin_en, wr_try_en, wr_lock_set;
    logic [IDX_W-1:0] wr_idx;

    logic [ACC_W-1:0] acc, acc_off;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_ok, accept, timeout_hit;
    logic [BAL_W-1:0] amount;
    logic [PIN_W-1:0] new_pin;
    logic [BAL_W:0]   dep_sum, cr_sum;
    logic [TRY_W-1:0] tries_inc;

    // Request account drives the single read port: the login account or
    // the transfer destination. The session balance is cached locally.
    assign acc       = ACC_W'(req_q.acc);
    assign acc_off   = acc - BASE;
    assign acc_ok    = (acc >= BASE) && ({1'b0, acc_off} < NUM);
    assign acc_idx   = acc_off[IDX_W-1:0];
    assign amount    = BAL_W'(req_q.amount);
    assign new_pin   = PIN_W'(req_q.pin);
    assign dep_sum   = {1'b0, sess_bal} + {1'b0, amount};
    assign cr_sum    = {1'b0, rd_bal} + {1'b0, amount};
    assign tries_inc = rd_tries + TRY_W'(1);

    assign timeout_hit = (state == S_SESSION) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign bus.req_ready = started &&
        ((state == S_IDLE) || ((state == S_SESSION) && !timeout_hit));
    assign accept = bus.req_valid && bus.req_ready;

    assign bus.resp_valid     = (state == S_RESP);
    assign bus.resp_status    = (state == S_RESP) ? status_q : 4'd0;
    assign bus.resp_balance   = (state == S_RESP) ? bal_q : '0;
    assign bus.session_active = sess_open;

    atm_account_store #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .IDX_W        (IDX_W),
        .PIN_W        (PIN_W),
        .BAL_W        (BAL_W),
        .TRY_W        (TRY_W),
        .DEFAULT_PIN  (DEFAULT_PIN),
        .INIT_BALANCE (INIT_BALANCE)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx      (acc_idx),
        .rd_bal      (rd_bal),
        .rd_pin      (rd_pin),
        .rd_tries    (rd_tries),
        .rd_lock     (rd_lock),
        .wr_idx      (wr_idx),
        .wr_bal_en   (wr_bal_en),
        .wr_bal      (wr_bal),
        .wr_pin_en   (wr_pin_en),
        .wr_pin      (wr_pin),
        .wr_try_en   (wr_try_en),
        .wr_try      (wr_try),
        .wr_lock_set (wr_lock_set)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            status_q  <= ST_OK;
            req_q     <= '0;
            started   <= 1'b0;
            sess_open <= 1'b0;
            sess_idx  <= '0;
            sess_bal  <= '0;
            bal_q     <= '0;
            credit_q  <= '0;
            dest_idx  <= '0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_n;
            status_q  <= status_n;
            started   <= 1'b1;
            sess_open <= sess_open_n;
            sess_idx  <= sess_idx_n;
            sess_bal  <= sess_bal_n;
            bal_q     <= bal_n;
            credit_q  <= credit_n;
            dest_idx  <= dest_idx_n;
            if (accept)
                req_q <= '{op: op_e'(bus.req_op), acc: ATM_ACC_W'(bus.req_acc),
                           pin: ATM_PIN_W'(bus.req_pin), amount: ATM_BAL_W'(bus.req_amount)};
            if ((state != S_SESSION) || accept)
                idle_cnt <= '0;
            else if (!timeout_hit)
                idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_n     = state;
        status_n    = status_q;
        bal_n       = bal_q;
        sess_open_n = sess_open;
        sess_idx_n  = sess_idx;
        sess_bal_n  = sess_bal;
        credit_n    = credit_q;
        dest_idx_n  = dest_idx;
        wr_idx      = sess_idx;
        wr_bal_en   = 1'b0;
        wr_bal      = '0;
        wr_pin_en   = 1'b0;
        wr_pin      = '0;
        wr_try_en   = 1'b0;
        wr_try      = '0;
        wr_lock_set = 1'b0;
        case (state)
            S_IDLE, S_SESSION: begin
                if (timeout_hit) begin
                    state_n     = S_RESP;
                    status_n    = ST_TIMEOUT;
                    bal_n       = '0;
                    sess_open_n = 1'b0;
                end else if (accept) begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_RESP;
                bal_n   = sess_open ? sess_bal : '0;
                if (req_q.op == OP_RSVD) begin
                    status_n = ST_BAD_OP;
                end else if (req_q.op == OP_LOGIN) begin
                    sess_open_n = 1'b0;
                    bal_n       = '0;
                    if (!acc_ok) begin
                        status_n = ST_BAD_ACC;
                    end else if (rd_lock) begin
                        status_n = ST_LOCKED;
                    end else if (rd_pin != new_pin) begin
                        wr_idx    = acc_idx;
                        wr_try_en = 1'b1;
                        wr_try    = tries_inc;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
                            wr_lock_set = 1'b1;
                            status_n    = ST_LOCKED;
                        end else begin
                            status_n = ST_BAD_PIN;
                        end
                    end else begin
                        wr_idx      = acc_idx;
                        wr_try_en   = 1'b1;
                        sess_open_n = 1'b1;
                        sess_idx_n  = acc_idx;
                        sess_bal_n  = rd_bal;
                        bal_n       = rd_bal;
                        status_n    = ST_OK;
                    end
                end else if (!sess_open) begin
                    status_n = ST_NO_SESSION;
                end else begin
                    status_n = ST_OK;
                    case (req_q.op)
                        OP_WITHDRAW: begin
                            if (amount > sess_bal) begin
                                status_n = ST_INSUFFICIENT;
                            end else begin
                                wr_bal_en  = 1'b1;
                                wr_bal     = sess_bal - amount;
                                sess_bal_n = sess_bal - amount;
                                bal_n      = sess_bal - amount;
                            end
                        end
                        OP_DEPOSIT: begin
                            if (dep_sum[BAL_W]) begin
                                status_n = ST_OVERFLOW;
                            end else begin
                                wr_bal_en  = 1'b1;
                                wr_bal     = dep_sum[BAL_W-1:0];
                                sess_bal_n = dep_sum[BAL_W-1:0];
                                bal_n      = dep_sum[BAL_W-1:0];
                            end
                        end
                        OP_TRANSFER: begin
                            // Every check precedes the debit so an error leaves both accounts intact.
                            if (!acc_ok || (acc_idx == sess_idx)) begin
                                status_n = ST_BAD_ACC;
                            end else if (amount > sess_bal) begin
                                status_n = ST_INSUFFICIENT;
                            end else if (cr_sum[BAL_W]) begin
                                status_n = ST_OVERFLOW;
                            end else begin
                                wr_bal_en  = 1'b1;
                                wr_bal     = sess_bal - amount;
                                sess_bal_n = sess_bal - amount;
                                bal_n      = sess_bal - amount;
                                credit_n   = cr_sum[BAL_W-1:0];
                                dest_idx_n = acc_idx;
                                state_n    = S_EXEC2;
                            end
                        end
                        OP_LOGOUT: begin
                            sess_open_n = 1'b0;
                            bal_n       = '0;
                        end
                        OP_CHANGE_PIN: begin
                            wr_pin_en = 1'b1;
                            wr_pin    = new_pin;
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC2: begin
                wr_idx    = dest_idx;
                wr_bal_en = 1'b1;
                wr_bal    = credit_q;
                state_n   = S_RESP;
            end
            S_RESP:  state_n = sess_open ? S_SESSION : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_atm_controller_mc.sv
module tb_atm_controller_mc;
    localparam int OK = 0, BAD_ACC = 1, BAD_PIN = 2, LOCKED = 3, NO_SESS = 4;
    localparam int INSUF = 5, OVF = 6, TMO = 7, BAD_OP = 8;
    localparam int BASE = 2176, NACC = 8, MAXBAL = 2047;

    typedef struct {
        int op; int acc; int pin; int amt; int st; int bal; int lat;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    // reference account model
    int m_bal [NACC];
    int m_pin [NACC];
    int m_tries [NACC];
    bit m_lock [NACC];
    int m_sess;
    int m_exp_bal, m_exp_lat;

    atm_controller_mc_if #(.ACC_W(12), .PIN_W(4), .BAL_W(11)) bus ();

    atm_controller_mc #(
        .NUM_ACCOUNTS(8), .ACC_W(12), .ACC_BASE(2176), .PIN_W(4), .DEFAULT_PIN(4'b0100),
        .BAL_W(11), .INIT_BALANCE(500), .MAX_TRIES(3), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) begin
            m_bal[i] = 500; m_pin[i] = 4 ^ i; m_tries[i] = 0; m_lock[i] = 0;
        end
        m_sess = -1;
    endtask

    // Returns the expected status; balance and latency land in m_exp_*.
    function automatic int model(input int op, input int acc, input int pin, input int amt);
        int idx = acc - BASE;
        bit in_rng = (idx >= 0) && (idx < NACC);
        m_exp_lat = 2;
        m_exp_bal = 0;
        if (op == 7) begin
            if (m_sess >= 0) m_exp_bal = m_bal[m_sess];
            return BAD_OP;
        end
        if (op == 0) begin
            m_sess = -1;
            if (!in_rng) return BAD_ACC;
            if (m_lock[idx]) return LOCKED;
            if (pin != m_pin[idx]) begin
                m_tries[idx]++;
                if (m_tries[idx] >= 3) begin m_lock[idx] = 1; return LOCKED; end
                return BAD_PIN;
            end
            m_tries[idx] = 0; m_sess = idx; m_exp_bal = m_bal[idx];
            return OK;
        end
        if (m_sess < 0) return NO_SESS;
        m_exp_bal = m_bal[m_sess];
        case (op)
            2: begin
                if (amt > m_bal[m_sess]) return INSUF;
                m_bal[m_sess] -= amt;
            end
            3: begin
                if (m_bal[m_sess] + amt > MAXBAL) return OVF;
                m_bal[m_sess] += amt;
            end
            4: begin
                if (!in_rng || idx == m_sess) return BAD_ACC;
                if (amt > m_bal[m_sess]) return INSUF;
                if (m_bal[idx] + amt > MAXBAL) return OVF;
                m_bal[m_sess] -= amt; m_bal[idx] += amt; m_exp_lat = 3;
            end
            5: begin m_sess = -1; m_exp_bal = 0; return OK; end
            6: m_pin[m_sess] = pin;
            default: ;
        endcase
        if (m_sess >= 0) m_exp_bal = m_bal[m_sess];
        return OK;
    endfunction

    // Drive one request and measure its response (lat=0 when no response arrives).
    task automatic send(input int op, input int acc, input int pin, input int amt,
                        output int st, output int bal, output int lat, output int sess,
                        output int pulse_ok);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'(op); bus.req_acc = 12'(acc);
        bus.req_pin = 4'(pin); bus.req_amount = 11'(amt);
        while (bus.req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        st = -1; bal = -1; lat = 0; sess = -1; pulse_ok = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                lat = c; st = int'(bus.resp_status); bal = int'(bus.resp_balance);
                sess = int'(bus.session_active);
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            pulse_ok = (bus.resp_valid === 1'b0) ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_acc = '0; bus.req_pin = '0; bus.req_amount = '0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.req_ready, bus.resp_valid, bus.session_active, bus.resp_status, bus.resp_balance} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b valid=%b sess=%b st=%0d bal=%0d, need all 0",
                     bus.req_ready, bus.resp_valid, bus.session_active, bus.resp_status, bus.resp_balance);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL ready_before_clock: got %b need 0", bus.req_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_clock: got %b need 1", bus.req_ready);
        end
    endtask

    task automatic test_session_ops();
        step_t t [10];
        int st, bal, lat, sess, pok;
        t = '{'{0, 2178, 6, 0, OK, 500, 2}, '{2, 0, 0, 100, OK, 400, 2},
              '{1, 0, 0, 0, OK, 400, 2},    '{2, 0, 0, 450, INSUF, 400, 2},
              '{7, 0, 0, 0, BAD_OP, 400, 2}, '{4, 2180, 0, 50, OK, 350, 3},
              '{5, 0, 0, 0, OK, 0, 2},      '{0, 2180, 0, 0, OK, 550, 2},
              '{3, 0, 0, 1500, OVF, 550, 2}, '{5, 0, 0, 0, OK, 0, 2}};
        for (int i = 0; i < 10; i++) begin
            send(t[i].op, t[i].acc, t[i].pin, t[i].amt, st, bal, lat, sess, pok);
            void'(model(t[i].op, t[i].acc, t[i].pin, t[i].amt));
            total++;
            if (st !== t[i].st || bal !== t[i].bal || lat !== t[i].lat || pok !== 1) begin
                bad++;
                $display("FAIL session_ops[%0d]: got st=%0d bal=%0d lat=%0d pulse=%0d, need st=%0d bal=%0d lat=%0d pulse=1",
                         i, st, bal, lat, pok, t[i].st, t[i].bal, t[i].lat);
            end
            total++;
            if (sess !== ((m_sess >= 0) ? 1 : 0)) begin
                bad++; $display("FAIL session_ops_active[%0d]: got %0d need %0d", i, sess, m_sess >= 0);
            end
        end
    endtask

    task automatic test_boundaries();
        step_t t [17];
        int st, bal, lat, sess, pok;
        t = '{'{0, 2181, 15, 0, BAD_PIN, 0, 2}, '{0, 2181, 15, 0, BAD_PIN, 0, 2},
              '{0, 2181, 15, 0, LOCKED, 0, 2},  '{0, 2181, 1, 0, LOCKED, 0, 2},
              '{0, 2175, 0, 0, BAD_ACC, 0, 2},  '{0, 2184, 0, 0, BAD_ACC, 0, 2},
              '{1, 0, 0, 0, NO_SESS, 0, 2},     '{0, 2182, 2, 0, OK, 500, 2},
              '{4, 2182, 0, 10, BAD_ACC, 500, 2}, '{2, 0, 0, 500, OK, 0, 2},
              '{2, 0, 0, 0, OK, 0, 2},          '{3, 0, 0, 2047, OK, 2047, 2},
              '{3, 0, 0, 1, OVF, 2047, 2},      '{4, 2176, 0, 2000, OVF, 2047, 2},
              '{6, 0, 9, 0, OK, 2047, 2},       '{0, 2182, 2, 0, BAD_PIN, 0, 2},
              '{0, 2182, 9, 0, OK, 2047, 2}};
        for (int i = 0; i < 17; i++) begin
            send(t[i].op, t[i].acc, t[i].pin, t[i].amt, st, bal, lat, sess, pok);
            void'(model(t[i].op, t[i].acc, t[i].pin, t[i].amt));
            total++;
            if (st !== t[i].st || bal !== t[i].bal || lat !== t[i].lat || pok !== 1) begin
                bad++;
                $display("FAIL boundaries[%0d]: got st=%0d bal=%0d lat=%0d pulse=%0d, need st=%0d bal=%0d lat=%0d pulse=1",
                         i, st, bal, lat, pok, t[i].st, t[i].bal, t[i].lat);
            end
        end
    endtask

    task automatic test_timeout();
        int st, bal, lat, sess, pok, k, prev_ready;
        send(0, 2183, 3, 0, st, bal, lat, sess, pok);
        void'(model(0, 2183, 3, 0));
        total++;
        if (st !== OK || bal !== 500 || sess !== 1) begin
            bad++; $display("FAIL timeout_login: got st=%0d bal=%0d sess=%0d need 0 500 1", st, bal, sess);
        end
        k = 0; prev_ready = 1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin k = c; break; end
            prev_ready = int'(bus.req_ready);
        end
        m_sess = -1;
        total++;
        if (k < 62 || k > 68 || bus.resp_status !== 4'(TMO) || bus.resp_balance !== '0 ||
            bus.session_active !== 1'b0 || prev_ready !== 0) begin
            bad++;
            $display("FAIL timeout_resp: got cycles=%0d st=%0d bal=%0d sess=%b ready_before=%0d, need cycles 62..68 st=7 bal=0 sess=0 ready_before=0",
                     k, bus.resp_status, bus.resp_balance, bus.session_active, prev_ready);
        end
        send(1, 0, 0, 0, st, bal, lat, sess, pok);
        total++;
        if (st !== NO_SESS || bal !== 0 || lat !== 2) begin
            bad++; $display("FAIL timeout_after: got st=%0d bal=%0d lat=%0d need 4 0 2", st, bal, lat);
        end
    endtask

    task automatic test_random();
        int st, bal, lat, sess, pok, op, acc, pin, amt, est, idx;
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 7);
            if (m_sess < 0 && $urandom_range(0, 1) == 1) op = 0;
            acc = (op == 0) ? $urandom_range(2174, 2185) : $urandom_range(2175, 2184);
            idx = acc - BASE;
            pin = $urandom_range(0, 15);
            if (op == 0 && idx >= 0 && idx < NACC && $urandom_range(0, 3) != 0) pin = m_pin[idx];
            amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 300);
            send(op, acc, pin, amt, st, bal, lat, sess, pok);
            est = model(op, acc, pin, amt);
            total++;
            if (st !== est || bal !== m_exp_bal || lat !== m_exp_lat || pok !== 1 ||
                sess !== ((m_sess >= 0) ? 1 : 0)) begin
                bad++;
                $display("FAIL random[%0d] op=%0d acc=%0d amt=%0d: got st=%0d bal=%0d lat=%0d sess=%0d pulse=%0d, need st=%0d bal=%0d lat=%0d sess=%0d pulse=1",
                         i, op, acc, amt, st, bal, lat, sess, pok, est, m_exp_bal, m_exp_lat, m_sess >= 0);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        int st, bal, lat, sess, pok;
        model_reset();
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        send(0, 2178, 6, 0, st, bal, lat, sess, pok);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_acc = 12'd2180; bus.req_amount = 11'd10;
        @(posedge clk);           // accepted
        #1 bus.req_valid = 1'b0;
        @(posedge clk);           // EXEC2 begins
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, bus.resp_valid, bus.session_active, bus.resp_status, bus.resp_balance} !== '0) begin
            bad++;
            $display("FAIL midxfer_reset_outputs: got ready=%b valid=%b sess=%b st=%0d bal=%0d, need all 0",
                     bus.req_ready, bus.resp_valid, bus.session_active, bus.resp_status, bus.resp_balance);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send(0, 2178, 6, 0, st, bal, lat, sess, pok);
        total++;
        if (st !== OK || bal !== 500) begin
            bad++; $display("FAIL midxfer_src: got st=%0d bal=%0d need 0 500", st, bal);
        end
        send(0, 2180, 0, 0, st, bal, lat, sess, pok);
        total++;
        if (st !== OK || bal !== 500) begin
            bad++; $display("FAIL midxfer_dst: got st=%0d bal=%0d need 0 500", st, bal);
        end
        send(0, 2181, 1, 0, st, bal, lat, sess, pok);
        total++;
        if (st !== OK || bal !== 500) begin
            bad++; $display("FAIL lock_cleared: got st=%0d bal=%0d need 0 500", st, bal);
        end
    endtask

    initial begin
        test_reset();
        test_session_ops();
        test_boundaries();
        test_timeout();
        test_random();
        test_reset_mid_transfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end
endmodule
